// File: rtl/vga_rx_monitor_if.sv
// VGA connector-side signals plus the recovered timing/pixel results of the receive monitor.
// The source (generator or bench) is master; the monitor is slave.
interface vga_rx_monitor_if;
  logic        hsync;
  logic        vsync;
  logic [7:0]  rgb;
  logic        locked;
  logic        pix_valid;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic [7:0]  pix_rgb;
  logic        frame_done;
  logic [15:0] frame_sum;
  logic [15:0] h_period;
  logic [10:0] v_lines;
  logic [7:0]  err_count;

  modport master (
    output hsync, vsync, rgb,
    input  locked, pix_valid, pix_x, pix_y, pix_rgb, frame_done, frame_sum, h_period,
           v_lines, err_count
  );

  modport slave (
    input  hsync, vsync, rgb,
    output locked, pix_valid, pix_x, pix_y, pix_rgb, frame_done, frame_sum, h_period,
           v_lines, err_count
  );
endinterface

// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: measures sync timing, locks via search/acquire/locked, and recovers
// pixel coordinates, colour and a per-frame checksum.
module vga_rx_monitor #(
  parameter int unsigned CLKS_PER_PIXEL = 4,
  parameter int unsigned H_TOTAL        = 800,
  parameter int unsigned H_START        = 144,
  parameter int unsigned H_VISIBLE      = 640,
  parameter int unsigned V_TOTAL        = 525,
  parameter int unsigned V_START        = 35,
  parameter int unsigned V_VISIBLE      = 480,
  parameter int unsigned LOCK_FRAMES    = 2
) (
  input logic              clk,
  input logic              reset_n,
  vga_rx_monitor_if.slave  bus
);

  localparam int unsigned LineClks     = H_TOTAL * CLKS_PER_PIXEL;
  localparam int unsigned TimeoutLines = 2 * V_TOTAL;

  typedef enum logic [1:0] {StSearch, StAcquire, StLocked} state_e;

  logic [1:0]  hs_sync_q, vs_sync_q;
  logic        hs_prev_q, vs_prev_q;
  logic [7:0]  rgb_d1_q, rgb_d2_q;
  logic [15:0] h_count_q, h_period_q;
  logic [10:0] line_count_q, v_lines_q;
  logic        line_bad_q;
  state_e      state_q;
  logic [7:0]  good_cnt_q, err_count_q;
  logic        locked_q, frame_done_q;
  logic [15:0] frame_sum_q, acc_q;
  logic        pix_valid_q;
  logic [10:0] pix_x_q, pix_y_q;
  logic [7:0]  pix_rgb_q;

  logic        hs_fall, vs_fall, timeout, frame_close, frame_good;
  logic [15:0] period_next, pix_col;
  logic        period_ok, x_in, y_in, pix_hit;

  assign hs_fall     = hs_prev_q & ~hs_sync_q[1];
  assign vs_fall     = vs_prev_q & ~vs_sync_q[1];
  assign period_next = (h_count_q == 16'hFFFF) ? 16'hFFFF : h_count_q + 16'd1;
  assign period_ok   = (period_next == 16'(LineClks));
  assign timeout     = ~vs_fall && (line_count_q >= 11'(TimeoutLines));
  assign frame_close = vs_fall | timeout;
  // A line ending in the closing cycle still belongs to the frame being closed.
  assign frame_good  = vs_fall && !line_bad_q && !(hs_fall && !period_ok) &&
                       (line_count_q == 11'(V_TOTAL));

  assign pix_col = h_count_q / 16'(CLKS_PER_PIXEL);
  assign x_in    = (pix_col >= 16'(H_START)) && (pix_col < 16'(H_START + H_VISIBLE));
  assign y_in    = (line_count_q >= 11'(V_START)) &&
                   (line_count_q < 11'(V_START + V_VISIBLE));
  assign pix_hit = (state_q == StLocked) && x_in && y_in &&
                   ((h_count_q % 16'(CLKS_PER_PIXEL)) == 16'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_sync_q <= '0;
      vs_sync_q <= '0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      rgb_d1_q  <= '0;
      rgb_d2_q  <= '0;
    end else begin
      hs_sync_q <= {hs_sync_q[0], bus.hsync};
      vs_sync_q <= {vs_sync_q[0], bus.vsync};
      hs_prev_q <= hs_sync_q[1];
      vs_prev_q <= vs_sync_q[1];
      rgb_d1_q  <= bus.rgb;
      rgb_d2_q  <= rgb_d1_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_count_q    <= '0;
      h_period_q   <= '0;
      line_count_q <= '0;
      v_lines_q    <= '0;
      line_bad_q   <= 1'b0;
    end else begin
      if (hs_fall) begin
        h_count_q  <= '0;
        h_period_q <= period_next;
      end else if (h_count_q != 16'hFFFF) begin
        h_count_q <= h_count_q + 16'd1;
      end
      if (frame_close) begin
        line_count_q <= hs_fall ? 11'd1 : 11'd0;
      end else if (hs_fall) begin
        line_count_q <= line_count_q + 11'd1;
      end
      if (vs_fall) v_lines_q <= line_count_q;
      if (frame_close)               line_bad_q <= 1'b0;
      else if (hs_fall && !period_ok) line_bad_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StSearch;
      good_cnt_q   <= '0;
      err_count_q  <= '0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_sum_q  <= '0;
      acc_q        <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (pix_hit) acc_q <= acc_q + {8'd0, rgb_d2_q};
      unique case (state_q)
        StSearch: begin
          if (vs_fall) state_q <= StAcquire;
        end
        StAcquire: begin
          if (timeout) begin
            state_q    <= StSearch;
            good_cnt_q <= '0;
          end else if (vs_fall) begin
            if (!frame_good) begin
              good_cnt_q <= '0;
            end else if (good_cnt_q + 8'd1 >= 8'(LOCK_FRAMES)) begin
              state_q    <= StLocked;
              locked_q   <= 1'b1;
              good_cnt_q <= '0;
            end else begin
              good_cnt_q <= good_cnt_q + 8'd1;
            end
          end
        end
        StLocked: begin
          if (frame_close) begin
            acc_q <= '0;
            if (frame_good) begin
              frame_done_q <= 1'b1;
              frame_sum_q  <= acc_q;
            end else begin
              state_q    <= StSearch;
              locked_q   <= 1'b0;
              good_cnt_q <= '0;
              if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
            end
          end
        end
        default: state_q <= StSearch;
      endcase
    end
  end

  // Coordinates and colour hold their last values between strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_rgb_q   <= '0;
    end else begin
      pix_valid_q <= pix_hit;
      if (pix_hit) begin
        pix_x_q   <= 11'(pix_col - 16'(H_START));
        pix_y_q   <= line_count_q - 11'(V_START);
        pix_rgb_q <= rgb_d2_q;
      end
    end
  end

  assign bus.locked     = locked_q;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_x      = pix_x_q;
  assign bus.pix_y      = pix_y_q;
  assign bus.pix_rgb    = pix_rgb_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_sum  = frame_sum_q;
  assign bus.h_period   = h_period_q;
  assign bus.v_lines    = v_lines_q;
  assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor using a miniature raster (16-clk lines, 5-line frames).
// Visible pixel (x,y) carries colour x + 16*y, so one frame sums to 16'h00D2.
module tb_vga_rx_monitor;
  localparam int CPP  = 2;
  localparam int HT   = 8;
  localparam int HS   = 3;
  localparam int HV   = 4;
  localparam int VT   = 5;
  localparam int VS   = 2;
  localparam int VV   = 3;
  localparam int LF   = 2;
  localparam int LINE = CPP * HT;
  localparam int SYNC = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  vga_rx_monitor_if bus ();

  vga_rx_monitor #(
    .CLKS_PER_PIXEL(CPP), .H_TOTAL(HT), .H_START(HS), .H_VISIBLE(HV),
    .V_TOTAL(VT), .V_START(VS), .V_VISIBLE(VV), .LOCK_FRAMES(LF)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Pixel/frame monitor; snapshots taken at each frame_done.
  int          pix_cnt = 0, snap_cnt = 0, done_cnt = 0, rgb_bad = 0;
  logic [10:0] fx = '0, fy = '0, lx = '0, ly = '0;
  logic [10:0] sfx = '0, sfy = '0, slx = '0, sly = '0;

  always @(negedge clk) begin
    if (bus.pix_valid) begin
      if (pix_cnt == 0) begin
        fx <= bus.pix_x;
        fy <= bus.pix_y;
      end
      lx      <= bus.pix_x;
      ly      <= bus.pix_y;
      pix_cnt <= pix_cnt + 1;
      if (bus.pix_rgb !== 8'(bus.pix_x + 16 * bus.pix_y)) rgb_bad <= rgb_bad + 1;
    end
    if (bus.frame_done) begin
      snap_cnt <= pix_cnt;
      sfx      <= fx;
      sfy      <= fy;
      slx      <= lx;
      sly      <= ly;
      done_cnt <= done_cnt + 1;
      pix_cnt  <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_line(input bit vs_pulse, input int clks, input int y);
    int px;
    for (int c = 0; c < clks; c++) begin
      @(negedge clk);
      px = c / CPP - HS;
      bus.hsync = (c < SYNC) ? 1'b0 : 1'b1;
      bus.vsync = (vs_pulse && c < SYNC) ? 1'b0 : 1'b1;
      if (y >= 0 && y < VV && px >= 0 && px < HV && c < LINE) bus.rgb = 8'(px + 16 * y);
      else bus.rgb = 8'd0;
    end
  endtask

  task automatic drive_frame(input int lines);
    for (int g = 0; g < lines; g++) drive_line(g == 0, LINE, g - 1);
  endtask

  initial begin
    bus.hsync = 1'b1;
    bus.vsync = 1'b1;
    bus.rgb   = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_locked", bus.locked, 0);
    check("reset_pix_valid", bus.pix_valid, 0);
    check("reset_pix_x", bus.pix_x, 0);
    check("reset_frame_done", bus.frame_done, 0);
    check("reset_frame_sum", bus.frame_sum, 0);
    check("reset_h_period", bus.h_period, 0);
    check("reset_v_lines", bus.v_lines, 0);
    check("reset_err_count", bus.err_count, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Edge 1 -> acquire, edge 2 -> one good frame, edge 3 -> locked.
    drive_frame(VT);
    drive_frame(VT);
    check("prelock_locked", bus.locked, 0);
    drive_frame(VT);
    check("lock_locked", bus.locked, 1);
    check("lock_h_period", bus.h_period, 16);
    check("lock_v_lines", bus.v_lines, 5);
    check("lock_err_count", bus.err_count, 0);

    drive_frame(VT);
    check("frame_done_count", done_cnt, 1);
    check("frame_pix_count", snap_cnt, 12);
    check("first_x", sfx, 0);
    check("first_y", sfy, 0);
    check("last_x", slx, 3);
    check("last_y", sly, 2);
    check("frame_sum", bus.frame_sum, 16'h00D2);
    check("pix_rgb_errors", rgb_bad, 0);

    // Frame with one 18-clk line.
    drive_line(1'b1, LINE, -1);
    drive_line(1'b0, LINE, 0);
    drive_line(1'b0, LINE + 2, 1);
    drive_line(1'b0, LINE, 2);
    check("stretch_h_period", bus.h_period, 18);
    check("stretch_still_locked", bus.locked, 1);
    drive_line(1'b0, LINE, 3);
    drive_frame(VT);
    check("stretch_unlocked", bus.locked, 0);
    check("stretch_err_count", bus.err_count, 1);
    check("stretch_no_done", done_cnt, 2);
    check("stretch_sum_held", bus.frame_sum, 16'h00D2);
    drive_frame(VT);
    drive_frame(VT);
    check("stretch_relock_pending", bus.locked, 0);
    drive_frame(VT);
    check("stretch_relocked", bus.locked, 1);

    // vsync held high: line count reaches 10 on the 5th extra line.
    drive_frame(VT);
    for (int i = 0; i < 4; i++) drive_line(1'b0, LINE, -1);
    check("timeout_before", bus.locked, 1);
    drive_line(1'b0, LINE, -1);
    check("timeout_unlocked", bus.locked, 0);
    check("timeout_err_count", bus.err_count, 2);
    drive_frame(VT);
    drive_frame(VT);
    check("timeout_relock_pending", bus.locked, 0);
    drive_frame(VT);
    check("timeout_relocked", bus.locked, 1);

    // Asynchronous reset mid-frame.
    drive_line(1'b1, LINE, -1);
    drive_line(1'b0, LINE, 0);
    reset_n = 1'b0;
    #1;
    check("async_locked", bus.locked, 0);
    check("async_err_count", bus.err_count, 0);
    check("async_h_period", bus.h_period, 0);
    check("async_v_lines", bus.v_lines, 0);
    check("async_frame_sum", bus.frame_sum, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Short frame during acquire delays lock by one frame.
    drive_frame(VT);
    drive_frame(VT - 1);
    drive_frame(VT);
    drive_frame(VT);
    check("short_lock_delayed", bus.locked, 0);
    drive_frame(VT);
    check("short_relocked", bus.locked, 1);
    check("short_err_count", bus.err_count, 0);

    // One lock loss per iteration; count saturates at 255.
    for (int i = 0; i < 254; i++) begin
      drive_frame(1);
      drive_frame(1);
      drive_frame(VT);
      drive_frame(VT);
    end
    check("loss_err_254", bus.err_count, 254);
    check("loss_locked", bus.locked, 0);
    for (int i = 0; i < 3; i++) begin
      drive_frame(1);
      drive_frame(1);
      drive_frame(VT);
      drive_frame(VT);
    end
    check("loss_err_sat", bus.err_count, 255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vga_rx_monitor.md
Name: vga_rx_monitor

Overview:
- Receive-side counterpart of the VGA sync generator. Samples hsync/vsync/rgb exactly as the generator drives them to the connector.
- Measures line period and lines per frame, and locks onto valid timing with a search/acquire/locked FSM.
- Recovers pixel coordinates and a per-frame pixel checksum.
- Used as a loopback/self-check block and as the bench scoreboard front-end for the graphics path.

Parameters:
- CLKS_PER_PIXEL, 4, clk cycles per pixel
- H_TOTAL, 800, pixels per line incl. blanking
- H_START, 144, pixels from hsync falling edge to first visible pixel
- H_VISIBLE, 640, visible pixels per line
- V_TOTAL, 525, lines per frame
- V_START, 35, lines from vsync falling edge to first visible line
- V_VISIBLE, 480, visible lines per frame
- LOCK_FRAMES, 2, consecutive good frames needed to lock

Ports:
- clk  in  1  system clock, one clock for the whole block
- reset_n  in  1  asynchronous, active-low reset
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low
- rgb  in  8  pixel colour
- locked  out  1  timing locked
- pix_valid  out  1  one-cycle strobe per visible pixel while locked
- pix_x  out  11  recovered x, valid with pix_valid
- pix_y  out  11  recovered y, valid with pix_valid
- pix_rgb  out  8  sampled colour, valid with pix_valid
- frame_done  out  1  one-cycle pulse when a frame closes while locked
- frame_sum  out  16  checksum of last completed locked frame
- h_period  out  16  last measured hsync-to-hsync clk count
- v_lines  out  11  last measured line count per frame
- err_count  out  8  lock losses, saturating

Behaviour:
- Reset: all outputs 0; FSM in SEARCH; all counters cleared.
- Input synchronisation:
  - hsync and vsync pass through a 2-flop synchroniser; rgb is delayed 2 flops to stay aligned.
  - A falling edge is detected on the synchronised signal, giving 3 cycles from pin to edge detect.
- Horizontal counter:
  - Cleared to 0 on each hsync falling edge, otherwise increments, saturating at 16'hFFFF.
  - On an hsync edge, h_period is loaded with the count + 1.
  - A line is good when h_period == H_TOTAL*CLKS_PER_PIXEL (3200).
- Line counter:
  - Increments on each hsync falling edge.
  - On a vsync falling edge the frame closes: v_lines is loaded with the line count and the counter resets to 0, or to 1 if an hsync edge falls in the same cycle (that line belongs to the new frame).
  - A frame is good when every line in it was good and v_lines == V_TOTAL.
- Timeout: if the line count reaches 2*V_TOTAL with no vsync edge, the frame is closed as bad.
- FSM:
  - SEARCH: the first vsync edge goes to ACQUIRE; no evaluation is made.
  - ACQUIRE: a good frame increments good_cnt. Reaching LOCK_FRAMES sets locked=1 and goes to LOCKED. A bad frame clears good_cnt and stays in ACQUIRE. A timeout goes to SEARCH.
  - LOCKED: a bad frame or timeout clears locked, increments err_count (saturating at 255), clears good_cnt and goes to SEARCH.
  - locked changes in the cycle after the closing edge is detected.
- Pixel recovery (LOCKED only):
  - Pixel p = h_count/CLKS_PER_PIXEL - H_START; line l = line_count - V_START.
  - When 0<=p<H_VISIBLE and 0<=l<V_VISIBLE, pix_valid pulses on the first clk of each pixel period.
  - pix_x=p, pix_y=l, pix_rgb = the delayed rgb sampled that cycle.
  - Each valid pix_rgb is added into a 16-bit accumulator, mod 2^16, zero-extended.
- Frame close in LOCKED:
  - On a good close: frame_sum is loaded with the accumulator, frame_done pulses one cycle, and the accumulator clears.
  - On a bad close: no frame_done, frame_sum is held, and the accumulator clears.
- Outside LOCKED: pix_valid=0 and frame_done=0; pix_x, pix_y and pix_rgb hold their values.
- Reset asserted mid-frame: immediate return to reset state; err_count clears; lock must be reacquired from SEARCH.

Test Plan:
- Nominal timing from the sync generator, rgb constant 0 → edge 1 enters ACQUIRE, locked=1 after the 3rd vsync edge; h_period=3200, v_lines=525, err_count=0.
- Locked, rgb = pix_x[7:0] → 307200 pix_valid pulses per frame; first pulse has x=0, y=0; last has x=639, y=479; frame_done with frame_sum=16'hA800.
- Locked, one line stretched to 3204 clks → h_period=3204; at the next vsync edge locked=0, state SEARCH, err_count=1, no frame_done; relock 3 frames later.
- Locked, vsync held high → after 1050 lines locked=0, err_count=1; restoring vsync relocks.
- Frame with 524 lines during ACQUIRE → good_cnt clears; lock is delayed by one frame; err_count stays 0.
- reset_n pulsed low mid-frame while locked → all outputs 0 asynchronously; relock after 3 vsync edges; 300 forced lock losses → err_count=255.
